hazard_stall_ctrl: RTL

- Pipeline sequencing controller for the 5-stage RISC-V core.
- Detects load-use hazards between ID and the ID/EX register, and resolves taken-branch flushes.
- Schedules a multi-cycle multiplier in EX: issues a start pulse, then freezes the front end and ID/EX for the multiplier latency before releasing.
- Drives the write-enable, flush and bubble controls of PC, IF/ID, ID/EX and EX/MEM.

---
 rtl/hazard_stall_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard / stall controller: load-use stalls, branch flushes and multi-cycle MUL freeze.
// Optional stall counter output enabled by defining HAZARD_STALL_CNT_EN.
module hazard_stall_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_uses_rs2_i,
  input  logic             id_branch_taken_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_is_mul_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_bubble_o,
  output logic             mul_start_o,
  output logic             mul_done_o,
`ifdef HAZARD_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cnt_o,
`endif
  output logic             busy_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    MUL_REL  = 2'd2
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(MUL_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use_s;
  logic       hazard_en_s;

  assign load_use_s = ex_mem_read_i && (ex_rd_addr_i != 5'd0) &&
                      ((ex_rd_addr_i == id_rs1_addr_i) ||
                       (id_uses_rs2_i && (ex_rd_addr_i == id_rs2_addr_i)));

  // Hazard logic only acts when the front end is not frozen by a multiply.
  assign hazard_en_s = ((state_q == RUN) && !ex_is_mul_i) || (state_q == MUL_REL);

  // State and sequence counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and pipeline control decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_write_o   = 1'b1;
    idex_bubble_o  = 1'b0;
    exmem_bubble_o = 1'b0;
    mul_start_o    = 1'b0;
    mul_done_o     = 1'b0;
    busy_o         = 1'b0;

    case (state_q)
      RUN: begin
        if (ex_is_mul_i) begin
          pc_write_o     = 1'b0;
          ifid_write_o   = 1'b0;
          idex_write_o   = 1'b0;
          exmem_bubble_o = 1'b1;
          busy_o         = 1'b1;
          mul_start_o    = 1'b1;
          cnt_d          = LAT_M1;
          state_d        = MUL_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      MUL_WAIT: begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        idex_write_o   = 1'b0;
        exmem_bubble_o = 1'b1;
        busy_o         = 1'b1;
        cnt_d          = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = MUL_REL;
        end else begin
          state_d = MUL_WAIT;
        end
      end
      MUL_REL: begin
        // The MUL still sitting in ID/EX is not re-issued; release goes straight to RUN.
        mul_done_o = 1'b1;
        busy_o     = 1'b1;
        state_d    = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase

    if (hazard_en_s) begin
      if (load_use_s) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end else if (id_branch_taken_i) begin
        ifid_flush_o = 1'b1;
      end else begin
        ifid_flush_o = 1'b0;
      end
    end else begin
      idex_bubble_o = 1'b0;
    end

    if (rst_i) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_write_o   = 1'b0;
      idex_bubble_o  = 1'b1;
      exmem_bubble_o = 1'b1;
      mul_start_o    = 1'b0;
      mul_done_o     = 1'b0;
      busy_o         = 1'b0;
    end else begin
      busy_o = busy_o;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Count cycles in which the PC is held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (!pc_write_o) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
